// File: rtl/nd_pkg.sv
// Shared types for the N-dimensional loop iterator.
// Default geometry and FSM state encoding.
package nd_pkg;

  localparam int ND_BW  = 8;
  localparam int ND_DIM = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } nd_iter_state_t;

  typedef logic [ND_BW-1:0] nd_idx_t;

endpackage

// File: rtl/nd_loop_iter_if.sv
// Configuration and index-tuple handshakes of nd_loop_iter.
// The slave side is the iterator; the master side feeds and drains it.
interface nd_loop_iter_if
  import nd_pkg::*;
#(
  parameter int BW  = ND_BW,
  parameter int DIM = ND_DIM
);

  logic                    i_cfg_rdy;
  logic                    o_cfg_ack;
  logic [DIM-1:0][BW-1:0]  i_beg;
  logic [DIM-1:0][BW-1:0]  i_stride;
  logic [DIM-1:0][BW-1:0]  i_end;
  logic                    o_id_rdy;
  logic                    i_id_ack;
  logic [DIM-1:0][BW-1:0]  o_id;
  logic [DIM-1:0][BW-1:0]  o_id_noofs;
  logic [DIM-1:0]          o_first;
  logic [DIM-1:0]          o_last;
  logic                    o_done;

  modport slave (
    input  i_cfg_rdy, i_beg, i_stride, i_end, i_id_ack,
    output o_cfg_ack, o_id_rdy, o_id, o_id_noofs,
    output o_first, o_last, o_done
  );

  modport master (
    output i_cfg_rdy, i_beg, i_stride, i_end, i_id_ack,
    input  o_cfg_ack, o_id_rdy, o_id, o_id_noofs,
    input  o_first, o_last, o_done
  );

endinterface

// File: rtl/nd_step.sv
// Combinational successor of an index tuple plus its boundary masks.
// With load set the successor is the begin tuple itself.
module nd_step #(
  parameter int BW  = 8,
  parameter int DIM = 3
) (
  input  logic [DIM-1:0][BW-1:0] cur_id,
  input  logic [DIM-1:0][BW-1:0] cur_noofs,
  input  logic [DIM-1:0][BW-1:0] beg,
  input  logic [DIM-1:0][BW-1:0] stride,
  input  logic [DIM-1:0][BW-1:0] lim,
  input  logic                   load,
  output logic [DIM-1:0][BW-1:0] nxt_id,
  output logic [DIM-1:0][BW-1:0] nxt_noofs,
  output logic [DIM-1:0]         nxt_first,
  output logic [DIM-1:0]         nxt_last,
  output logic                   carry
);

  logic [BW-1:0] sum;
  logic [BW-1:0] peek;
  logic          c;
  logic          f;
  logic          l;

  always_comb begin
    sum       = '0;
    peek      = '0;
    c         = 1'b1;
    f         = 1'b1;
    l         = 1'b1;
    nxt_id    = cur_id;
    nxt_noofs = cur_noofs;
    nxt_first = '0;
    nxt_last  = '0;
    // ripple the carry from the innermost dimension outwards
    for (int d = DIM - 1; d >= 0; d--) begin
      sum = cur_id[d] + stride[d];
      if (c) begin
        if (sum == lim[d]) begin
          nxt_id[d]    = beg[d];
          nxt_noofs[d] = '0;
        end else begin
          nxt_id[d]    = sum;
          nxt_noofs[d] = cur_noofs[d] + stride[d];
          c            = 1'b0;
        end
      end
    end
    carry = c;
    if (load) begin
      nxt_id    = beg;
      nxt_noofs = '0;
    end
    for (int d = DIM - 1; d >= 0; d--) begin
      peek         = nxt_id[d] + stride[d];
      f            = f & (nxt_id[d] == beg[d]);
      l            = l & (peek == lim[d]);
      nxt_first[d] = f;
      nxt_last[d]  = l;
    end
  end

endmodule

// File: rtl/nd_loop_iter.sv
// Stallable N-dimensional loop iterator, row-major, dim 0 outermost.
// Holds the nest configuration and registers every emitted tuple.
module nd_loop_iter
  import nd_pkg::*;
#(
  parameter int BW          = ND_BW,
  parameter int DIM         = ND_DIM,
  parameter int FROM_ZERO   = 0,
  parameter int UNIT_STRIDE = 0
) (
  input logic            i_clk,
  input logic            i_rst,
  nd_loop_iter_if.slave  bus
);

  typedef logic [DIM-1:0][BW-1:0] vec_t;

  nd_iter_state_t state_q, state_d;

  vec_t           beg_q, beg_d;
  vec_t           stride_q, stride_d;
  vec_t           end_q, end_d;
  vec_t           id_q, id_d;
  vec_t           noofs_q, noofs_d;
  logic [DIM-1:0] first_q, first_d;
  logic [DIM-1:0] last_q, last_d;
  logic           done_q, done_d;

  vec_t           in_beg, in_stride;
  vec_t           s_beg, s_stride, s_end;
  vec_t           nxt_id, nxt_noofs;
  logic [DIM-1:0] nxt_first, nxt_last;
  logic           wrap;
  logic           emp;
  logic           is_idle;
  logic           accept;
  logic           load;
  logic           adv;

  always_comb begin
    emp = 1'b0;
    for (int d = 0; d < DIM; d++) begin
      in_beg[d]    = (FROM_ZERO != 0) ? '0 : bus.i_beg[d];
      in_stride[d] = (UNIT_STRIDE != 0) ? BW'(1) : bus.i_stride[d];
      if (in_beg[d] == bus.i_end[d]) emp = 1'b1;
    end
  end

  assign is_idle = (state_q == IDLE);
  assign accept  = is_idle & bus.i_cfg_rdy;
  assign load    = accept & ~emp;
  assign adv     = ~is_idle & bus.i_id_ack;

  // in IDLE the step unit sees the incoming config to form the first tuple
  assign s_beg    = is_idle ? in_beg    : beg_q;
  assign s_stride = is_idle ? in_stride : stride_q;
  assign s_end    = is_idle ? bus.i_end : end_q;

  nd_step #(.BW(BW), .DIM(DIM)) u_step (
    .cur_id    (id_q),
    .cur_noofs (noofs_q),
    .beg       (s_beg),
    .stride    (s_stride),
    .lim       (s_end),
    .load      (load),
    .nxt_id    (nxt_id),
    .nxt_noofs (nxt_noofs),
    .nxt_first (nxt_first),
    .nxt_last  (nxt_last),
    .carry     (wrap)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load)       state_d = RUN;
      RUN:     if (adv & wrap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done_d   = (accept & emp) | (adv & wrap);
    beg_d    = beg_q;
    stride_d = stride_q;
    end_d    = end_q;
    id_d     = id_q;
    noofs_d  = noofs_q;
    first_d  = first_q;
    last_d   = last_q;
    if (accept) begin
      beg_d    = in_beg;
      stride_d = in_stride;
      end_d    = bus.i_end;
    end
    if (load | (adv & ~wrap)) begin
      id_d    = nxt_id;
      noofs_d = nxt_noofs;
      first_d = nxt_first;
      last_d  = nxt_last;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beg_q    <= '0;
      stride_q <= '0;
      end_q    <= '0;
      id_q     <= '0;
      noofs_q  <= '0;
      first_q  <= '0;
      last_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      beg_q    <= beg_d;
      stride_q <= stride_d;
      end_q    <= end_d;
      id_q     <= id_d;
      noofs_q  <= noofs_d;
      first_q  <= first_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_cfg_ack  = is_idle;
  assign bus.o_id_rdy   = ~is_idle;
  assign bus.o_id       = id_q;
  assign bus.o_id_noofs = noofs_q;
  assign bus.o_first    = first_q;
  assign bus.o_last     = last_q;
  assign bus.o_done     = done_q;

endmodule

// File: tb/tb_nd_loop_iter.sv
// Directed and randomized bench for nd_loop_iter (BW=8, DIM=2).
// Expected tuples come from a nested-loop model of the iteration space.
module tb_nd_loop_iter;
  import nd_pkg::*;

  localparam int BW  = 8;
  localparam int DIM = 2;

  typedef logic [DIM-1:0][BW-1:0] vec_t;
  typedef struct {
    vec_t           id;
    vec_t           nf;
    logic [DIM-1:0] first;
    logic [DIM-1:0] last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nd_loop_iter_if #(.BW(BW), .DIM(DIM)) bus ();

  nd_loop_iter #(
    .BW(BW), .DIM(DIM), .FROM_ZERO(0), .UNIT_STRIDE(0)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    pat    = 0;

  function automatic vec_t mk(input int a0, input int a1);
    vec_t v;
    v[0] = BW'(a0);
    v[1] = BW'(a1);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Model: dimension d takes n_d = ((end-beg) mod 2^BW)/stride values.
  task automatic do_cfg(input vec_t b, input vec_t s, input vec_t e);
    logic [BW-1:0] diff;
    int            n[DIM];
    beat_t         x;
    q.delete();
    for (int d = 0; d < DIM; d++) begin
      diff = e[d] - b[d];
      n[d] = int'(diff) / int'(s[d]);
    end
    for (int k0 = 0; k0 < n[0]; k0++) begin
      for (int k1 = 0; k1 < n[1]; k1++) begin
        x.nf[0]    = BW'(k0 * int'(s[0]));
        x.nf[1]    = BW'(k1 * int'(s[1]));
        x.id[0]    = b[0] + x.nf[0];
        x.id[1]    = b[1] + x.nf[1];
        x.first[1] = (k1 == 0);
        x.first[0] = (k1 == 0) && (k0 == 0);
        x.last[1]  = (k1 == n[1] - 1);
        x.last[0]  = (k1 == n[1] - 1) && (k0 == n[0] - 1);
        q.push_back(x);
      end
    end
    bus.i_beg     = b;
    bus.i_stride  = s;
    bus.i_end     = e;
    bus.i_cfg_rdy = 1'b1;
  endtask

  // Called at the negedge one cycle after the configuration edge.
  task automatic beats(input int mode, input bit b2b,
                       input vec_t nb, input vec_t ns, input vec_t ne);
    bit ack;
    bit fin;
    int budget;
    bus.i_cfg_rdy = 1'b0;
    if (q.size() == 0) begin
      chk("empty_done", 32'(bus.o_done), 1);
      chk("empty_rdy", 32'(bus.o_id_rdy), 0);
      chk("empty_cfg_ack", 32'(bus.o_cfg_ack), 1);
      return;
    end
    chk("first_ones", 32'(bus.o_first), 32'({DIM{1'b1}}));
    fin    = 1'b0;
    budget = 0;
    while (!fin) begin
      chk("rdy", 32'(bus.o_id_rdy), 1);
      chk("cfg_ack_low", 32'(bus.o_cfg_ack), 0);
      chk("done_low", 32'(bus.o_done), 0);
      chk("id", 32'(bus.o_id), 32'(q[0].id));
      chk("noofs", 32'(bus.o_id_noofs), 32'(q[0].nf));
      chk("first", 32'(bus.o_first), 32'(q[0].first));
      chk("last", 32'(bus.o_last), 32'(q[0].last));
      case (mode)
        0:       ack = 1'b1;
        1:       ack = 1'($urandom_range(0, 1));
        default: ack = (pat % 3 == 0);
      endcase
      pat++;
      bus.i_id_ack = ack;
      if (ack) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          fin = 1'b1;
          if (b2b) do_cfg(nb, ns, ne);
        end
      end
      @(negedge clk);
      budget++;
      if (budget > 400) begin
        chk("timeout", 0, 1);
        fin = 1'b1;
      end
    end
    bus.i_id_ack = 1'b0;
    chk("done_pulse", 32'(bus.o_done), 1);
    chk("done_cfg_ack", 32'(bus.o_cfg_ack), 1);
    chk("done_rdy", 32'(bus.o_id_rdy), 0);
  endtask

  task automatic nest(input vec_t b, input vec_t s, input vec_t e,
                      input int mode);
    do_cfg(b, s, e);
    @(negedge clk);
    beats(mode, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("post_done_low", 32'(bus.o_done), 0);
    chk("post_cfg_ack", 32'(bus.o_cfg_ack), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cfg_ack"}, 32'(bus.o_cfg_ack), 1);
    chk({tag, "_rdy"}, 32'(bus.o_id_rdy), 0);
    chk({tag, "_done"}, 32'(bus.o_done), 0);
    chk({tag, "_id"}, 32'(bus.o_id), 0);
    chk({tag, "_noofs"}, 32'(bus.o_id_noofs), 0);
    chk({tag, "_first"}, 32'(bus.o_first), 0);
    chk({tag, "_last"}, 32'(bus.o_last), 0);
  endtask

  initial begin
    vec_t b;
    vec_t s;
    vec_t e;
    int   n0;
    int   n1;
    bus.i_cfg_rdy = 1'b0;
    bus.i_id_ack  = 1'b0;
    bus.i_beg     = '0;
    bus.i_stride  = '0;
    bus.i_end     = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // basic nest, ack held high
    nest(mk(0, 0), mk(1, 1), mk(2, 3), 0);
    // back-pressure pattern 1,0,0,1,...
    nest(mk(0, 0), mk(1, 1), mk(2, 3), 2);
    // wrap past 255 with stride 3: 250, 253, 0
    nest(mk(0, 250), mk(1, 3), mk(1, 3), 0);
    // empty inner dimension
    nest(mk(0, 0), mk(1, 1), mk(4, 0), 0);

    // back-to-back: second config held while the first drains
    do_cfg(mk(5, 7), mk(2, 1), mk(9, 9));
    @(negedge clk);
    beats(0, 1'b1, mk(1, 2), mk(1, 2), mk(3, 8));
    @(negedge clk);
    beats(1, 1'b0, '0, '0, '0);
    @(negedge clk);

    // reset on the third beat
    do_cfg(mk(0, 0), mk(1, 1), mk(2, 3));
    @(negedge clk);
    bus.i_cfg_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_run_id", 32'(bus.o_id), 32'(q[0].id));
      void'(q.pop_front());
      bus.i_id_ack = 1'b1;
      if (i == 2) rst = 1'b1;
      @(negedge clk);
    end
    chk_reset_vals("midrun_rst");
    rst          = 1'b0;
    bus.i_id_ack = 1'b0;
    q.delete();
    @(negedge clk);
    nest(mk(0, 0), mk(1, 1), mk(2, 3), 0);

    // randomized nests inside the stride/end contract
    for (int it = 0; it < 12; it++) begin
      n0   = $urandom_range(1, 3);
      n1   = (it == 5) ? 0 : $urandom_range(1, 4);
      b    = mk($urandom_range(0, 255), $urandom_range(0, 255));
      s    = mk($urandom_range(1, 9), $urandom_range(1, 9));
      e[0] = b[0] + BW'(n0 * int'(s[0]));
      e[1] = b[1] + BW'(n1 * int'(s[1]));
      nest(b, s, e, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
